// File: rtl/hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module  : hex_display_scanner
// Brief   : Multiplexed common-anode 7-segment scanner with per-digit blanking,
//           leading-zero suppression and dead time between digit slots.
//           Blinking is included only when HEX_DISPLAY_BLINK_EN is defined.
// Revision: 1.0
// ============================================================================
module hex_display_scanner #(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lz_suppress,
`ifdef HEX_DISPLAY_BLINK_EN
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic [3:0]            blink_rate,
`endif
    output logic [6:0]            hex,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  slot_tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [6:0]        SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] EN_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic [6:0]            hex_q, hex_d;
    logic [DIGITS-1:0]     en_q, en_d;
    logic                  tick_q, tick_d;

    logic                  slot_end;
    logic                  dead;
    logic                  blank;
    logic                  zero_run;
    logic                  lead_zero;
    logic                  mask_bit;
    logic [3:0]            nib;
    logic [6:0]            seg_al;
    logic [DIGITS-1:0]     onehot;

    // Glyphs in active-low form (bit6 = g ... bit0 = a)
    function automatic logic [6:0] glyph_al(input logic [3:0] n);
        case (n)
            4'h0:    glyph_al = 7'b1000000;
            4'h1:    glyph_al = 7'b1111001;
            4'h2:    glyph_al = 7'b0100100;
            4'h3:    glyph_al = 7'b0110000;
            4'h4:    glyph_al = 7'b0011001;
            4'h5:    glyph_al = 7'b0010010;
            4'h6:    glyph_al = 7'b0000010;
            4'h7:    glyph_al = 7'b1111000;
            4'h8:    glyph_al = 7'b0000000;
            4'h9:    glyph_al = 7'b0010000;
            4'hA:    glyph_al = 7'b0001000;
            4'hB:    glyph_al = 7'b0000011;
            4'hC:    glyph_al = 7'b1000110;
            4'hD:    glyph_al = 7'b0100001;
            4'hE:    glyph_al = 7'b0000110;
            default: glyph_al = 7'b0001110;
        endcase
    endfunction

`ifdef HEX_DISPLAY_BLINK_EN
    logic [15:0] frame_q, frame_d;
    logic        phase_q, phase_d;
    logic        blink_bit;
`endif

    always_comb begin
        slot_end = (cnt_q == CW'(PRESCALE - 1));
        dead     = (cnt_q == '0);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        shadow_d = load ? value : shadow_q;

        // Walk from the most significant digit down so zero_run tracks whether
        // every nibble from k upwards is zero when k reaches the current digit.
        zero_run  = 1'b1;
        lead_zero = 1'b0;
        mask_bit  = 1'b0;
        nib       = 4'h0;
        onehot    = '0;
`ifdef HEX_DISPLAY_BLINK_EN
        blink_bit = 1'b0;
`endif
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (shadow_q[4*k +: 4] != 4'h0) begin
                zero_run = 1'b0;
            end
            if (idx_q == IW'(k)) begin
                nib       = shadow_q[4*k +: 4];
                lead_zero = zero_run;
                mask_bit  = blank_mask[k];
                onehot[k] = ~dead;
`ifdef HEX_DISPLAY_BLINK_EN
                blink_bit = blink_mask[k];
`endif
            end
        end

        blank = mask_bit | (lz_suppress & (idx_q != '0) & lead_zero);
`ifdef HEX_DISPLAY_BLINK_EN
        blank = blank | (phase_q & blink_bit);
`endif
        seg_al = blank ? 7'h7F : glyph_al(nib);
        hex_d  = (ACTIVE_LOW != 0) ? seg_al : ~seg_al;
        en_d   = (ACTIVE_LOW != 0) ? ~onehot : onehot;
        tick_d = slot_end;
    end

`ifdef HEX_DISPLAY_BLINK_EN
    // Phase flips after 2^blink_rate complete frames; >= tolerates a live rate drop.
    always_comb begin
        frame_d = frame_q;
        phase_d = phase_q;
        if (slot_end && (idx_q == IW'(DIGITS - 1))) begin
            if (frame_q >= ((16'd1 << blink_rate) - 16'd1)) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q <= '0;
            phase_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            hex_q    <= SEG_OFF;
            en_q     <= EN_OFF;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            hex_q    <= hex_d;
            en_q     <= en_d;
            tick_q   <= tick_d;
        end
    end

    assign hex       = hex_q;
    assign digit_en  = en_q;
    assign slot_tick = tick_q;

endmodule
`default_nettype wire
